// File: rtl/pc_pkg.sv
// Shared types and default constants for the IF-stage program-counter unit.
package pc_pkg;

   localparam int unsigned DEF_XLEN        = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } pc_state_e;

   typedef enum logic [2:0] {
      EXC   = 3'd0,
      REDIR = 3'd1,
      HOLD  = 3'd2,
      RET   = 3'd3,
      JMP   = 3'd4,
      SEQ   = 3'd5
   } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned XLEN      = DEF_XLEN,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_push_data,
   output logic [XLEN-1:0] o_top,
   output logic            o_empty,
   output logic            o_full
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [XLEN-1:0]  r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_empty;
   logic             r_full;

   logic [PTR_W-1:0] w_ptr_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   // r_ptr is the next write slot; when full it also addresses the oldest entry
   always_comb begin
      w_ptr_nxt   = r_ptr;
      w_count_nxt = r_count;
      if (i_clear) begin
         w_ptr_nxt   = '0;
         w_count_nxt = '0;
      end else if (i_push) begin
         w_ptr_nxt = r_ptr + PTR_W'(1);
         if (r_count != CNT_FULL) w_count_nxt = r_count + CNT_W'(1);
      end else if (i_pop && (r_count != '0)) begin
         w_ptr_nxt   = r_ptr - PTR_W'(1);
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr   <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_FULL);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !i_clear && i_push) r_mem[r_ptr] <= i_push_data;
   end

   assign o_top   = r_mem[r_ptr - PTR_W'(1)];
   assign o_empty = r_empty;
   assign o_full  = r_full;

endmodule

// File: rtl/pc_unit.sv
// IF-stage program-counter generator: start/idle/trap FSM, prioritised
// next-PC select, return-address stack and target alignment.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = DEF_XLEN,
   parameter int unsigned     INSTR_BYTES  = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            exc_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            jump_i,
   input  logic            call_i,
   input  logic            ret_i,
   input  logic [XLEN-1:0] jump_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            valid_o,
   output logic            misalign_o,
   output logic            ras_empty_o,
   output logic            ras_full_o
);

   localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

   pc_state_e       r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_valid;
   logic            r_misalign;

   pc_state_e       w_state_nxt;
   pc_sel_e         w_sel;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_pc_plus;
   logic            w_misalign_nxt;
   logic            w_push;
   logic            w_pop;
   logic            w_clear;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_ras_full;

   assign w_pc_plus = r_pc + INC;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_pc       <= RESET_VECTOR;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_valid    <= (w_state_nxt == RUN);
         r_misalign <= w_misalign_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sel          = HOLD;
      w_pc_nxt       = r_pc;
      w_misalign_nxt = 1'b0;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_clear        = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_pc_nxt = RESET_VECTOR;
            if (start_i) w_state_nxt = RUN;
         end
         // the vector slot itself is never a valid fetch; resume one past it
         TRAP: begin
            w_pc_nxt    = w_pc_plus;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (exc_i)           w_sel = EXC;
            else if (redirect_i) w_sel = REDIR;
            else if (stall_i)    w_sel = HOLD;
            else if (ret_i)      w_sel = RET;
            else if (jump_i)     w_sel = JMP;
            else                 w_sel = SEQ;

            unique case (w_sel)
               EXC: begin
                  w_pc_nxt    = EXC_VECTOR;
                  w_clear     = 1'b1;
                  w_state_nxt = TRAP;
               end
               REDIR: begin
                  w_pc_nxt       = redirect_pc_i & ~ALIGN_MASK;
                  w_misalign_nxt = |(redirect_pc_i & ALIGN_MASK);
               end
               RET: begin
                  if (!w_ras_empty) begin
                     w_pc_nxt = w_ras_top;
                     w_pop    = 1'b1;
                  end else begin
                     w_pc_nxt       = jump_target_i & ~ALIGN_MASK;
                     w_misalign_nxt = |(jump_target_i & ALIGN_MASK);
                  end
               end
               JMP: begin
                  w_pc_nxt       = jump_target_i & ~ALIGN_MASK;
                  w_misalign_nxt = |(jump_target_i & ALIGN_MASK);
                  w_push         = call_i;
               end
               SEQ:     w_pc_nxt = w_pc_plus;
               default: w_pc_nxt = r_pc;
            endcase
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_clear     (w_clear),
      .i_push_data (w_pc_plus),
      .o_top       (w_ras_top),
      .o_empty     (w_ras_empty),
      .o_full      (w_ras_full)
   );

   assign pc_o        = r_pc;
   assign pc_plus_o   = w_pc_plus;
   assign valid_o     = r_valid;
   assign misalign_o  = r_misalign;
   assign ras_empty_o = w_ras_empty;
   assign ras_full_o  = w_ras_full;

endmodule
